// File: rtl/deal_ctrl_pkg.sv
// Shared game constants, FSM encoding and index helper for the card-deal initiator.
package deal_ctrl_pkg;

    localparam int unsigned DECK_SIZE = 106;
    localparam int unsigned IDX_W     = 7;
    localparam int unsigned MAX_DEAL  = 14;
    localparam int unsigned CNT_W     = 5;

    // Matches the draw responder's reset value for "no card chosen".
    localparam logic [IDX_W-1:0] IDX_INVALID = IDX_W'(110);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ    = 3'd1,
        ST_WAIT   = 3'd2,
        ST_COMMIT = 3'd3,
        ST_FIN    = 3'd4
    } deal_state_t;

    // One-hot select of a deck slot; indexes beyond the deck shift out to all zeros.
    function automatic logic [DECK_SIZE-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
        return DECK_SIZE'(1) << idx;
    endfunction

endpackage

// File: rtl/deal_ctrl.sv
// Deal initiator: owns the deck bitmap and requests one card at a time from the
// draw responder until the requested count is dealt or the deal cannot continue.
module deal_ctrl
    import deal_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 interboard_rst,
    input  logic                 deal_start,
    input  logic [CNT_W-1:0]     deal_num,
    input  logic                 deck_init,
    input  logic                 return_valid,
    input  logic [IDX_W-1:0]     return_idx,
    input  logic                 draw_ready,
    input  logic                 draw_done,
    input  logic [IDX_W-1:0]     drawn_card_idx,
    output logic                 draw_one,
    output logic [DECK_SIZE-1:0] available_card,
    output logic [DECK_SIZE-1:0] deal_mask,
    output logic [CNT_W-1:0]     dealt_cnt,
    output logic                 busy,
    output logic                 deal_done,
    output logic                 deal_short
);

    localparam logic [DECK_SIZE-1:0] DECK_FULL  = '1;
    localparam logic [CNT_W-1:0]     MAX_DEAL_C = CNT_W'(MAX_DEAL);

    deal_state_t          r_state;
    logic [DECK_SIZE-1:0] r_avail;
    logic [DECK_SIZE-1:0] r_mask;
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     r_target;
    logic [IDX_W-1:0]     r_idx;
    logic                 r_draw_one;
    logic                 r_busy;
    logic                 r_deal_done;
    logic                 r_short;

    logic [DECK_SIZE-1:0] w_ret_sel;
    logic [DECK_SIZE-1:0] w_idx_sel;
    logic                 w_idx_ok;
    logic [CNT_W-1:0]     w_cnt_next;
    logic [CNT_W-1:0]     w_target;

    assign w_ret_sel  = idx_onehot(return_idx);
    assign w_idx_sel  = idx_onehot(r_idx);
    assign w_idx_ok   = |(r_avail & w_idx_sel);
    assign w_cnt_next = r_cnt + CNT_W'(1);
    assign w_target   = (deal_num > MAX_DEAL_C) ? MAX_DEAL_C : deal_num;

    // Deal FSM with deck/mask bookkeeping; all outputs are registered here.
    always_ff @(posedge clk) begin
        if (rst || interboard_rst) begin
            r_state     <= ST_IDLE;
            r_avail     <= DECK_FULL;
            r_mask      <= '0;
            r_cnt       <= '0;
            r_target    <= '0;
            r_idx       <= IDX_INVALID;
            r_draw_one  <= 1'b0;
            r_busy      <= 1'b0;
            r_deal_done <= 1'b0;
            r_short     <= 1'b0;
        end else begin
            r_draw_one  <= 1'b0;
            r_deal_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (deck_init) begin
                        r_avail <= DECK_FULL;
                    end else if (return_valid) begin
                        r_avail <= r_avail | w_ret_sel;
                    end
                    if (deal_start) begin
                        r_target <= w_target;
                        r_mask   <= '0;
                        r_cnt    <= '0;
                        r_short  <= 1'b0;
                        r_busy   <= 1'b1;
                        if (w_target == '0) begin
                            r_state     <= ST_FIN;
                            r_deal_done <= 1'b1;
                        end else begin
                            r_state <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    // An empty deck would stall the responder forever, so never request.
                    if (r_avail == '0) begin
                        r_short     <= 1'b1;
                        r_state     <= ST_FIN;
                        r_deal_done <= 1'b1;
                    end else if (draw_ready) begin
                        r_draw_one <= 1'b1;
                        r_state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (draw_done) begin
                        r_idx   <= drawn_card_idx;
                        r_state <= ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    if (!w_idx_ok) begin
                        r_short     <= 1'b1;
                        r_state     <= ST_FIN;
                        r_deal_done <= 1'b1;
                    end else begin
                        r_avail <= r_avail & ~w_idx_sel;
                        r_mask  <= r_mask | w_idx_sel;
                        r_cnt   <= w_cnt_next;
                        if (w_cnt_next == r_target) begin
                            r_state     <= ST_FIN;
                            r_deal_done <= 1'b1;
                        end else begin
                            r_state <= ST_REQ;
                        end
                    end
                end
                ST_FIN: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign draw_one       = r_draw_one;
    assign available_card = r_avail;
    assign deal_mask      = r_mask;
    assign dealt_cnt      = r_cnt;
    assign busy           = r_busy;
    assign deal_done      = r_deal_done;
    assign deal_short     = r_short;

endmodule

// File: tb/tb_deal_ctrl.sv
// Randomized scoreboard bench for deal_ctrl with a stub draw responder and a
// behavioural deck model.
module tb_deal_ctrl;
    import deal_ctrl_pkg::*;

    localparam int NC = 106;
    typedef logic [NC-1:0] deck_t;
    typedef struct {
        int    cnt;
        bit    sh;
        deck_t av;
        deck_t mk;
    } exp_t;

    logic             clk            = 1'b0;
    logic             rst            = 1'b1;
    logic             interboard_rst = 1'b0;
    logic             deal_start     = 1'b0;
    logic [CNT_W-1:0] deal_num       = '0;
    logic             deck_init      = 1'b0;
    logic             return_valid   = 1'b0;
    logic [IDX_W-1:0] return_idx     = '0;
    logic             draw_ready     = 1'b0;
    logic             draw_done      = 1'b0;
    logic [IDX_W-1:0] drawn_card_idx = '0;
    logic             draw_one;
    deck_t            available_card;
    deck_t            deal_mask;
    logic [CNT_W-1:0] dealt_cnt;
    logic             busy;
    logic             deal_done;
    logic             deal_short;

    int    vectors     = 0;
    int    fails       = 0;
    exp_t  exp_q[$];
    int    idx_q[$];
    deck_t model_avail = '1;
    int    done_cnt    = 0;
    int    draw_pulses = 0;
    int    unexp_draws = 0;
    int    fixed_lat   = -1;
    bit    prev_ready  = 1'b0;
    bit    rsp_pending = 1'b0;
    int    rsp_lat     = 0;
    int    rsp_idx     = 0;
    exp_t  mon_e;

    deal_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .interboard_rst (interboard_rst),
        .deal_start     (deal_start),
        .deal_num       (deal_num),
        .deck_init      (deck_init),
        .return_valid   (return_valid),
        .return_idx     (return_idx),
        .draw_ready     (draw_ready),
        .draw_done      (draw_done),
        .drawn_card_idx (drawn_card_idx),
        .draw_one       (draw_one),
        .available_card (available_card),
        .deal_mask      (deal_mask),
        .dealt_cnt      (dealt_cnt),
        .busy           (busy),
        .deal_done      (deal_done),
        .deal_short     (deal_short)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int pick(input deck_t v);
        int s;
        s = $urandom_range(0, NC - 1);
        for (int k = 0; k < NC; k++) begin
            int i;
            i = (s + k) % NC;
            if (v[i]) return i;
        end
        return 110;
    endfunction

    // Stub responder: answers each draw_one with the next scripted index after a short delay.
    always @(posedge clk) begin
        #1;
        draw_done = 1'b0;
        if (rsp_pending) begin
            if (rsp_lat == 0) begin
                draw_done      = 1'b1;
                drawn_card_idx = IDX_W'(rsp_idx);
                rsp_pending    = 1'b0;
            end else begin
                rsp_lat--;
            end
        end else if (draw_one === 1'b1) begin
            rsp_pending = 1'b1;
            rsp_lat     = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
            if (idx_q.size() > 0) begin
                rsp_idx = idx_q.pop_front();
            end else begin
                rsp_idx = 110;
                unexp_draws++;
            end
        end
        draw_ready = !rsp_pending && ($urandom_range(0, 3) != 0);
    end

    // Monitor: pops one expected result per deal_done and checks handshake ordering.
    always @(negedge clk) begin
        if (draw_one === 1'b1) begin
            draw_pulses++;
            chk("draw_after_ready", 128'(prev_ready), 128'(1));
        end
        prev_ready = draw_ready;
        if (deal_done === 1'b1) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                vectors++;
                fails++;
                $display("FAIL unexpected_deal_done: got 1 expected 0");
            end else begin
                mon_e = exp_q.pop_front();
                chk("dealt_cnt", 128'(dealt_cnt), 128'(mon_e.cnt));
                chk("deal_short", 128'(deal_short), 128'(mon_e.sh));
                chk("available_card", 128'(available_card), 128'(mon_e.av));
                chk("deal_mask", 128'(deal_mask), 128'(mon_e.mk));
                chk("busy_in_fin", 128'(busy), 128'(1));
                chk("draws_consumed", 128'(idx_q.size()), 128'(0));
                chk("no_extra_draw", 128'(unexp_draws), 128'(0));
            end
        end
    end

    task automatic clear_pulses();
        deal_start   = 1'b0;
        deck_init    = 1'b0;
        return_valid = 1'b0;
    endtask

    // same_op: bit0 = return ret, bit1 = deck_init, both on the deal_start cycle.
    task automatic run_deal(input int n, input int mode, input int same_op, input int ret);
        exp_t  e;
        deck_t d;
        int    tgt;
        int    start_done;
        bit    got;
        if (same_op[1]) model_avail = '1;
        else if (same_op[0] && ret < NC) model_avail[ret] = 1'b1;
        tgt   = (n > int'(MAX_DEAL)) ? int'(MAX_DEAL) : n;
        d     = model_avail;
        e.cnt = 0;
        e.sh  = 1'b0;
        e.mk  = '0;
        for (int k = 0; k < tgt; k++) begin
            int idx;
            if (d == '0) begin
                e.sh = 1'b1;
                break;
            end
            if (mode == 1 && k == 0) begin
                idx_q.push_back(110);
                e.sh = 1'b1;
                break;
            end
            if (mode == 2 && k == 0 && ~d != '0) begin
                idx_q.push_back(pick(~d));
                e.sh = 1'b1;
                break;
            end
            idx = pick(d);
            idx_q.push_back(idx);
            d[idx]    = 1'b0;
            e.mk[idx] = 1'b1;
            e.cnt++;
        end
        e.av        = d;
        model_avail = d;
        exp_q.push_back(e);

        start_done = done_cnt;
        @(posedge clk); #1;
        deal_start   = 1'b1;
        deal_num     = CNT_W'(n);
        return_valid = same_op[0];
        return_idx   = IDX_W'(ret);
        deck_init    = same_op[1];
        @(posedge clk); #1;
        clear_pulses();
        got = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            int r;
            if (done_cnt != start_done) begin
                got = 1'b1;
                break;
            end
            r = $urandom_range(0, 7);
            if (r == 0) begin
                return_valid = 1'b1;
                return_idx   = IDX_W'(5);
            end else if (r == 1) begin
                deck_init = 1'b1;
            end else if (r == 2) begin
                deal_start = 1'b1;
                deal_num   = CNT_W'($urandom_range(0, 20));
            end
            @(posedge clk); #1;
            clear_pulses();
        end
        if (!got) begin
            vectors++;
            fails++;
            $display("FAIL deal_timeout: got no deal_done expected deal_done n=%0d", n);
        end else begin
            chk("short_held", 128'(deal_short), 128'(e.sh));
            chk("idle_after_fin", 128'(busy), 128'(0));
        end
    endtask

    // op: bit0 = return ret, bit1 = deck_init, issued in IDLE.
    task automatic idle_op(input int op, input int ret);
        @(posedge clk); #1;
        return_valid = op[0];
        return_idx   = IDX_W'(ret);
        deck_init    = op[1];
        @(posedge clk); #1;
        clear_pulses();
        if (op[1]) model_avail = '1;
        else if (op[0] && ret < NC) model_avail[ret] = 1'b1;
        chk("idle_deck", 128'(available_card), 128'(model_avail));
    endtask

    task automatic rst_mid(input bit use_ib);
        int t0;
        int p0;
        bit seen;
        t0        = done_cnt;
        seen      = 1'b0;
        fixed_lat = 1;
        idx_q.push_back(pick(model_avail));
        @(posedge clk); #1;
        deal_start = 1'b1;
        deal_num   = CNT_W'(5);
        @(posedge clk); #1;
        clear_pulses();
        for (int c = 0; c < 200; c++) begin
            if (draw_one === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        chk("rst_draw_seen", 128'(seen), 128'(1));
        if (use_ib) interboard_rst = 1'b1;
        else rst = 1'b1;
        @(posedge clk); #1;
        rst            = 1'b0;
        interboard_rst = 1'b0;
        p0             = draw_pulses;
        repeat (12) @(posedge clk);
        #1;
        model_avail = '1;
        fixed_lat   = -1;
        chk("rst_no_deal_done", 128'(done_cnt), 128'(t0));
        chk("rst_no_draw", 128'(draw_pulses), 128'(p0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_draw_one", 128'(draw_one), 128'(0));
        chk("rst_deck", 128'(available_card), 128'(model_avail));
        chk("rst_mask", 128'(deal_mask), 128'(0));
        chk("rst_cnt", 128'(dealt_cnt), 128'(0));
        chk("rst_idx_q", 128'(idx_q.size()), 128'(0));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_deck", 128'(available_card), 128'(model_avail));
        chk("reset_mask", 128'(deal_mask), 128'(0));
        chk("reset_cnt", 128'(dealt_cnt), 128'(0));
        chk("reset_busy", 128'(busy), 128'(0));
        chk("reset_draw_one", 128'(draw_one), 128'(0));
        chk("reset_deal_done", 128'(deal_done), 128'(0));
        chk("reset_short", 128'(deal_short), 128'(0));
        rst = 1'b0;

        run_deal(1, 0, 0, 0);
        run_deal(14, 0, 0, 0);
        chk("pop_after_15", 128'($countones(available_card)), 128'(NC - 15));

        idle_op(2, 0);
        for (int i = 0; i < 7; i++) run_deal(14, 0, 0, 0);
        run_deal(6, 0, 0, 0);
        chk("pop_after_104", 128'($countones(available_card)), 128'(2));
        run_deal(3, 0, 0, 0);
        chk("deck_empty", 128'(available_card), 128'(0));

        idle_op(2, 0);
        run_deal(5, 1, 0, 0);
        run_deal(2, 0, 0, 0);
        run_deal(5, 2, 0, 0);
        idle_op(1, 5);
        idle_op(1, 120);
        idle_op(3, 5);
        run_deal(20, 0, 0, 0);
        run_deal(0, 0, 1, 7);

        rst_mid(1'b0);
        rst_mid(1'b1);

        for (int it = 0; it < 40; it++) begin
            int nops;
            int m;
            int so;
            nops = $urandom_range(0, 3);
            for (int j = 0; j < nops; j++) begin
                idle_op((($urandom_range(0, 9) == 0) ? 2 : 1), int'($urandom_range(0, 127)));
            end
            m  = $urandom_range(0, 9);
            so = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
            run_deal(int'($urandom_range(0, 20)), (m == 0) ? 1 : ((m == 1) ? 2 : 0),
                     so, int'($urandom_range(0, 127)));
        end

        repeat (5) @(posedge clk);
        chk("exp_q_drained", 128'(exp_q.size()), 128'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/deal_ctrl.md
Name: deal_ctrl

Overview:
- Initiator side of the single-card draw handshake (draw_one / ready / done / drawn_card_idx).
- Owns the 106-bit deck-availability register and issues one draw request per card until the requested count is dealt.
- Captures each returned index, removes that card from the deck, and records it in a per-deal mask.
- Sits between GameControl and the random-draw responder; also accepts cards returned to the deck.

Parameters:
- DECK_SIZE, 106, number of card slots in the deck bitmap.
- IDX_W, 7, width of a card index.
- MAX_DEAL, 14, largest number of cards dealt by one deal_start.
- CNT_W, 5, width of deal_num and dealt_cnt.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- interboard_rst  in  1  synchronous active-high reset from the peer board; same effect as rst
- deal_start  in  1  one-cycle pulse: begin dealing deal_num cards
- deal_num  in  CNT_W  cards to deal; sampled on the deal_start cycle
- deck_init  in  1  one-cycle pulse: mark every card available
- return_valid  in  1  one-cycle pulse: put return_idx back into the deck
- return_idx  in  IDX_W  index of the returned card
- draw_ready  in  1  responder is idle and can accept draw_one
- draw_done  in  1  responder result is valid this cycle
- drawn_card_idx  in  IDX_W  index chosen by the responder; valid while draw_done=1
- draw_one  out  1  one-cycle draw request to the responder
- available_card  out  DECK_SIZE  deck bitmap; 1 = card can be drawn
- deal_mask  out  DECK_SIZE  cards dealt by the current/last deal
- dealt_cnt  out  CNT_W  cards dealt so far in the current deal
- busy  out  1  high in every state except IDLE
- deal_done  out  1  one-cycle pulse when a deal ends
- deal_short  out  1  last deal ended before reaching deal_num; held until the next deal_start

Behaviour:
- Reset (either reset input, synchronous, highest priority, valid in any state including mid-deal):
  - state=IDLE; available_card all ones; deal_mask=0; dealt_cnt=0.
  - draw_one=0; deal_done=0; deal_short=0.
  - Any outstanding request is abandoned; a later draw_done is ignored because the block is in IDLE.
- IDLE:
  - deck_init sets available_card to all ones.
  - Otherwise, return_valid with return_idx<DECK_SIZE sets that bit. Returning an already-set bit is a no-op. return_idx>=DECK_SIZE is ignored.
  - deck_init and return_valid in the same cycle: deck_init wins.
  - On deal_start, latch target=min(deal_num, MAX_DEAL); clear deal_mask, dealt_cnt and deal_short.
  - Target==0 -> FIN. Otherwise -> REQ.
  - deck_init/return_valid in the same cycle as deal_start are still applied, so REQ sees the updated deck.
- REQ:
  - If available_card==0 -> FIN with deal_short=1. A request must never be issued on an empty deck; the responder's modulo-by-zero never completes.
  - Else, if draw_ready=1, assert draw_one for exactly this cycle and go to WAIT.
  - Else stay in REQ.
- WAIT:
  - available_card is frozen here; the responder scans it over about 106 cycles.
  - On draw_done, register drawn_card_idx and go to COMMIT.
  - draw_one stays 0.
- COMMIT:
  - If the captured idx>=DECK_SIZE or its available bit is 0: no deck change, deal_short=1, go to FIN (protocol error).
  - Else clear available_card[idx], set deal_mask[idx], increment dealt_cnt.
  - Then go to FIN if dealt_cnt+1==target, otherwise back to REQ.
- FIN:
  - deal_done=1 for this one cycle, then IDLE.
- While busy: deal_start, deck_init and return_valid are ignored (dropped, not queued).
- Per-card latency: 1 cycle in REQ (when draw_ready is already high) + responder latency + 1 COMMIT cycle.
- draw_one is registered; no combinational path from any input to any output.

Decomposition:
- Shared package (game constants):
  - DECK_SIZE, IDX_W, MAX_DEAL, CNT_W.
  - State encodings IDLE/REQ/WAIT/COMMIT/FIN (3-bit).
  - Invalid-index sentinel 110, matching the responder's reset value.
- No sub-module: a single FSM plus deck register. The draw responder is instantiated beside this block by the parent, not inside it.

Test Plan:
- Reset, then deal_start with deal_num=1, using the real draw responder -> exactly one draw_one pulse; deal_done pulses once. available_card has 105 ones; deal_mask has one bit set, at drawn_card_idx; dealt_cnt=1; deal_short=0.
- deal_num=14 from a full deck -> 14 draw_one pulses, each only after draw_ready. deal_mask has 14 distinct bits; popcount(available_card)=92; dealt_cnt=14; deal_short=0.
- Clear the deck with 104 draws, then deal_num=3 -> 2 cards dealt. REQ sees an empty deck and ends with no third draw_one. deal_short=1; dealt_cnt=2; available_card=0.
- Stub responder returns drawn_card_idx=110, then a second run returns an already-taken index -> no deck change; deal_short=1; deal_done pulses once.
- return_valid with idx 5 while busy -> ignored. In IDLE, return idx 5 with deck_init in the same cycle -> deck all ones. deal_num=20 -> clamped to 14 draws.
- Assert rst in WAIT, then the stub raises draw_done one cycle later -> block stays IDLE; deck all ones; no deal_done; draw_one=0.
